// File: rtl/freq_meter_if.sv
// Host-side bus of the frequency meter: start request, status and results.
// master = host (drives start, reads results); slave = the meter.
interface freq_meter_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ref_cnt;
    logic [CNT_W-1:0] sig_cnt;
    logic             overflow;
    logic             no_signal;

    modport master (
        output start,
        input  busy, done, ref_cnt, sig_cnt, overflow, no_signal
    );

    modport slave (
        input  start,
        output busy, done, ref_cnt, sig_cnt, overflow, no_signal
    );
endinterface

// File: rtl/freq_meter.sv
// Equal-precision frequency meter. The gate opens and closes on sig_in rising
// edges; the block reports clk cycles (ref_cnt) and signal periods (sig_cnt)
// across the gate. f_sig = sig_cnt * f_clk / ref_cnt is left to the host.
// Optional build macro FREQ_METER_AUTO_EN: continuous mode, re-arming the gate
// after every result; without it each measurement needs a start pulse.
module freq_meter #(
    parameter int          CNT_W          = 32,
    parameter logic [31:0] GATE_CYCLES    = 32'd125000000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sig_in,
    freq_meter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_OPEN,
        S_MEASURE,
        S_DONE,
        S_ABORT
    } state_t;

    // Largest value a result counter can hold, expressed on 33 bits.
    localparam logic [32:0] RES_MAX = (CNT_W >= 33) ? {33{1'b1}}
                                                    : ((33'd1 << CNT_W) - 33'd1);

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q, sync3_q;
    logic               edge_det;
    logic               busy_q, busy_d;
    logic [31:0]        elapsed_q, elapsed_d;
    logic [31:0]        idle_q, idle_d;
    logic [31:0]        sigc_q, sigc_d;
    logic [CNT_W-1:0]   ref_q, ref_d;
    logic [CNT_W-1:0]   sigr_q, sigr_d;
    logic               ovf_q, ovf_d;
    logic               nos_q, nos_d;

    logic [32:0]        elapsed_inc;
    logic [32:0]        sigc_inc;
    logic [31:0]        elapsed_next;
    logic               timeout_hit;

    // Clamp a 33-bit count to the result width.
    function automatic logic [CNT_W-1:0] sat_res(input logic [32:0] v);
        if (v > RES_MAX)
            return CNT_W'(RES_MAX);
        else
            return CNT_W'(v);
    endfunction

    // True when a 33-bit count does not fit the result width.
    function automatic logic sat_hit(input logic [32:0] v);
        return (v > RES_MAX);
    endfunction

    // 2-FF synchronizer plus a delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_det     = sync2_q & ~sync3_q;
    assign elapsed_inc  = {1'b0, elapsed_q} + 33'd1;
    assign sigc_inc     = {1'b0, sigc_q} + 33'd1;
    assign elapsed_next = (elapsed_q == 32'hFFFF_FFFF) ? elapsed_q : elapsed_q + 32'd1;
    assign timeout_hit  = ({1'b0, idle_q} + 33'd1) >= {1'b0, TIMEOUT_CYCLES};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            elapsed_q <= '0;
            idle_q    <= '0;
            sigc_q    <= '0;
            ref_q     <= '0;
            sigr_q    <= '0;
            ovf_q     <= 1'b0;
            nos_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            elapsed_q <= elapsed_d;
            idle_q    <= idle_d;
            sigc_q    <= sigc_d;
            ref_q     <= ref_d;
            sigr_q    <= sigr_d;
            ovf_q     <= ovf_d;
            nos_q     <= nos_d;
        end
    end

    // Next-state logic; results are latched on entry to DONE/ABORT so they
    // are already valid while done is high.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        elapsed_d = elapsed_q;
        idle_d    = idle_q;
        sigc_d    = sigc_q;
        ref_d     = ref_q;
        sigr_d    = sigr_q;
        ovf_d     = ovf_q;
        nos_d     = nos_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_WAIT_OPEN;
                    busy_d  = 1'b1;
                    idle_d  = '0;
                end
            end

            S_WAIT_OPEN: begin
                if (edge_det) begin
                    state_d   = S_MEASURE;
                    elapsed_d = '0;
                    sigc_d    = '0;
                    idle_d    = '0;
                end else if (timeout_hit) begin
                    state_d = S_ABORT;
                    ref_d   = '0;
                    sigr_d  = '0;
                    ovf_d   = 1'b0;
                    nos_d   = 1'b1;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
            end

            S_MEASURE: begin
                if (edge_det) begin
                    if (elapsed_inc >= {1'b0, GATE_CYCLES}) begin
                        state_d = S_DONE;
                        ref_d   = sat_res(elapsed_inc);
                        sigr_d  = sat_res(sigc_inc);
                        ovf_d   = sat_hit(elapsed_inc) | sat_hit(sigc_inc);
                        nos_d   = 1'b0;
                    end else begin
                        sigc_d    = (sigc_q == 32'hFFFF_FFFF) ? sigc_q : sigc_q + 32'd1;
                        idle_d    = '0;
                        elapsed_d = elapsed_next;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ABORT;
                    ref_d   = '0;
                    sigr_d  = '0;
                    ovf_d   = 1'b0;
                    nos_d   = 1'b1;
                end else begin
                    idle_d    = idle_q + 32'd1;
                    elapsed_d = elapsed_next;
                end
            end

            S_DONE, S_ABORT: begin
`ifdef FREQ_METER_AUTO_EN
                state_d = S_WAIT_OPEN;
                idle_d  = '0;
`else
                state_d = S_IDLE;
                busy_d  = 1'b0;
`endif
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = (state_q == S_DONE) || (state_q == S_ABORT);
    assign bus.ref_cnt   = ref_q;
    assign bus.sig_cnt   = sigr_q;
    assign bus.overflow  = ovf_q;
    assign bus.no_signal = nos_q;

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter: two instances (32-bit results, gate 100; 8-bit
// results, gate 300) with a result scoreboard per instance.
module tb_freq_meter;

    typedef struct {
        logic [31:0] r;
        logic [31:0] s;
        logic        o;
        logic        n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sig_a = 1'b0;
    logic sig_b = 1'b0;
    int   per_a = 0;
    int   per_b = 0;
    int   total = 0;
    int   bad = 0;
    int   cur_a;
    int   cur_b;
    exp_t q_a[$];
    exp_t q_b[$];

    freq_meter_if #(.CNT_W(32)) bus_a ();
    freq_meter_if #(.CNT_W(8))  bus_b ();

    freq_meter #(
        .CNT_W(32), .GATE_CYCLES(32'd100), .TIMEOUT_CYCLES(32'd500)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_a), .bus(bus_a)
    );

    freq_meter #(
        .CNT_W(8), .GATE_CYCLES(32'd300), .TIMEOUT_CYCLES(32'd500)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_b), .bus(bus_b)
    );

    always #4 clk = ~clk;

    // Periodic test signals, period in whole clk cycles (0 = held low).
    always begin
        cur_a = per_a;
        if (cur_a == 0) begin
            sig_a = 1'b0;
            @(negedge clk);
        end else begin
            sig_a = 1'b1;
            repeat (cur_a / 2) @(negedge clk);
            sig_a = 1'b0;
            repeat (cur_a - cur_a / 2) @(negedge clk);
        end
    end

    always begin
        cur_b = per_b;
        if (cur_b == 0) begin
            sig_b = 1'b0;
            @(negedge clk);
        end else begin
            sig_b = 1'b1;
            repeat (cur_b / 2) @(negedge clk);
            sig_b = 1'b0;
            repeat (cur_b - cur_b / 2) @(negedge clk);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [31:0] s,
                                input logic o, input logic n);
        exp_t e;
        e.r = r;
        e.s = s;
        e.o = o;
        e.n = n;
        return e;
    endfunction

    // Monitor A: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus_a.done) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_ref_cnt",   64'(bus_a.ref_cnt),   64'(e.r));
                chk("a_sig_cnt",   64'(bus_a.sig_cnt),   64'(e.s));
                chk("a_overflow",  64'(bus_a.overflow),  64'(e.o));
                chk("a_no_signal", 64'(bus_a.no_signal), 64'(e.n));
                chk("a_busy_at_done", 64'(bus_a.busy),   64'd1);
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (rst_n && bus_b.done) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_ref_cnt",   64'(bus_b.ref_cnt),   64'(e.r));
                chk("b_sig_cnt",   64'(bus_b.sig_cnt),   64'(e.s));
                chk("b_overflow",  64'(bus_b.overflow),  64'(e.o));
                chk("b_no_signal", 64'(bus_b.no_signal), 64'(e.n));
            end
        end
    end

    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 0) bus_a.start = 1'b1; else bus_b.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    task automatic wait_drain(input int which, input int budget, output int cyc);
        cyc = 0;
        while (((which == 0) ? q_a.size() : q_b.size()) != 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk((which == 0) ? "a_result_wait" : "b_result_wait",
            64'(((which == 0) ? q_a.size() : q_b.size())), 64'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},      64'(bus_a.busy),      64'd0);
        chk({tag, "_done"},      64'(bus_a.done),      64'd0);
        chk({tag, "_ref_cnt"},   64'(bus_a.ref_cnt),   64'd0);
        chk({tag, "_sig_cnt"},   64'(bus_a.sig_cnt),   64'd0);
        chk({tag, "_overflow"},  64'(bus_a.overflow),  64'd0);
        chk({tag, "_no_signal"}, 64'(bus_a.no_signal), 64'd0);
        chk({tag, "_b_busy"},    64'(bus_b.busy),      64'd0);
        chk({tag, "_b_ref_cnt"}, 64'(bus_b.ref_cnt),   64'd0);
        chk({tag, "_b_overflow"},64'(bus_b.overflow),  64'd0);
    endtask

    initial begin
        int cyc;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef FREQ_METER_AUTO_EN
        // Continuous mode: one start, several results, busy stays high.
        per_a = 10;
        repeat (30) @(negedge clk);
        q_a.push_back(mk(32'd100, 32'd10, 1'b0, 1'b0));
        q_a.push_back(mk(32'd100, 32'd10, 1'b0, 1'b0));
        q_a.push_back(mk(32'd100, 32'd10, 1'b0, 1'b0));
        pulse_start(0);
        wait_drain(0, 1000, cyc);
        chk("auto_busy_held", 64'(bus_a.busy), 64'd1);
        pulse_start(0);
        q_a.push_back(mk(32'd100, 32'd10, 1'b0, 1'b0));
        wait_drain(0, 300, cyc);
        chk("auto_busy_held2", 64'(bus_a.busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("auto_reset_busy", 64'(bus_a.busy), 64'd0);
`else
        // Timeout: signal held low, result is an abort.
        per_a = 0;
        repeat (20) @(negedge clk);
        q_a.push_back(mk(32'd0, 32'd0, 1'b0, 1'b1));
        pulse_start(0);
        chk("a_busy_after_start", 64'(bus_a.busy), 64'd1);
        wait_drain(0, 1000, cyc);
        chk("a_timeout_late_enough", 64'(cyc >= 480), 64'd1);
        @(negedge clk);
        chk("a_busy_after_abort", 64'(bus_a.busy), 64'd0);

        // Period 10: gate closes exactly at 100; no_signal cleared.
        per_a = 10;
        repeat (30) @(negedge clk);
        q_a.push_back(mk(32'd100, 32'd10, 1'b0, 1'b0));
        pulse_start(0);
        wait_drain(0, 400, cyc);

        // Period 7: first edge past the gate is at 105.
        per_a = 7;
        repeat (30) @(negedge clk);
        q_a.push_back(mk(32'd105, 32'd15, 1'b0, 1'b0));
        pulse_start(0);
        wait_drain(0, 400, cyc);
        @(negedge clk);
        chk("a_ref_hold", 64'(bus_a.ref_cnt), 64'd105);

        // 8-bit results: ref saturates at 255 and overflow is flagged.
        per_b = 10;
        repeat (30) @(negedge clk);
        q_b.push_back(mk(32'd255, 32'd30, 1'b1, 1'b0));
        pulse_start(1);
        wait_drain(1, 800, cyc);

        // A second start mid-measurement must not restart the gate.
        per_a = 10;
        repeat (30) @(negedge clk);
        q_a.push_back(mk(32'd100, 32'd10, 1'b0, 1'b0));
        pulse_start(0);
        repeat (50) @(negedge clk);
        pulse_start(0);
        wait_drain(0, 400, cyc);
        chk("a_no_restart", 64'(cyc <= 70), 64'd1);
        repeat (150) @(negedge clk);

        // Reset in the middle of a measurement: outputs clear, no done.
        pulse_start(0);
        repeat (40) @(negedge clk);
        chk("a_busy_mid", 64'(bus_a.busy), 64'd1);
        rst_n = 1'b0;
        #2;
        chk_idle_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("a_idle_after_reset", 64'(bus_a.busy), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Equal-precision frequency meter for the measurement side of the frequency-meter / waveform-generator design. Runs on the 125 MHz PLL output clock and measures an external asynchronous signal. Both the measurement gate open and the gate close are aligned to sig_in rising edges. Reports two counts: reference-clock cycles (ref_cnt) and signal periods (sig_cnt) across the gate. The host computes f_sig = sig_cnt * 125e6 / ref_cnt; no divider is in this block.

Parameters:
CNT_W, 32, width of the ref_cnt and sig_cnt result counters
GATE_CYCLES, 125000000, minimum gate length in clk cycles (1 s at 125 MHz); range 1..2^32-1
TIMEOUT_CYCLES, 250000000, max clk cycles allowed without a detected sig edge before abort; range 1..2^32-1

Ports:
clk  in  1  125 MHz reference clock (PLL c0)
rst_n  in  1  asynchronous active-low reset
sig_in  in  1  measured signal, asynchronous to clk
start  in  1  single-cycle request to begin a measurement
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when results are valid
ref_cnt  out  CNT_W  clk cycles between opening and closing edges
sig_cnt  out  CNT_W  sig_in rising edges counted, closing edge included
overflow  out  1  a result counter saturated during this measurement
no_signal  out  1  measurement aborted by timeout

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All state is cleared on rst_n low.
- Reset values: busy=0, done=0, ref_cnt=0, sig_cnt=0, overflow=0, no_signal=0, FSM in IDLE.
- Input conditioning: sig_in passes through a 2-FF synchronizer, then a third register. Edge detect is s2 & ~s3. Latency from pin to edge is 3 clk. Both gate edges see the same latency, so no bias.
- Internal 32-bit counters:
  - elapsed: clk cycles since the opening edge.
  - idle: clk cycles since the last detected edge.
- IDLE:
  - start=1 -> WAIT_OPEN, busy<=1, idle<=0.
- WAIT_OPEN:
  - on edge -> MEASURE; elapsed<=0, internal sig count<=0, idle<=0.
  - if idle reaches TIMEOUT_CYCLES -> ABORT.
- MEASURE:
  - elapsed increments every cycle; each edge increments sig count and clears idle.
  - Closing edge is the first edge with elapsed+1 >= GATE_CYCLES. On it, latch ref_cnt = elapsed+1 and sig_cnt = sig count+1, then go to DONE.
  - if idle reaches TIMEOUT_CYCLES -> ABORT.
- DONE: done=1 for one cycle, busy<=0, -> IDLE.
- ABORT:
  - latch ref_cnt=0, sig_cnt=0, no_signal=1, overflow=0.
  - done=1 for one cycle, busy<=0, -> IDLE.
- Width rule: result counters are CNT_W wide and saturate at 2^CNT_W-1. Any saturation sets overflow, latched at done. The internal elapsed counter is 32-bit, independent of CNT_W.
- Output persistence: ref_cnt, sig_cnt, overflow and no_signal hold until the next done. A successful done clears no_signal.
- start while busy: ignored, no restart.
- start and edge on the same cycle in IDLE: the edge is not used as the opening edge (WAIT_OPEN starts next cycle).
- rst_n low mid-measurement: immediate return to reset values, no done pulse.

Optional Feature:
FREQ_METER_AUTO_EN
- Defined: continuous mode. After DONE or ABORT the FSM goes directly to WAIT_OPEN. busy stays high after the first start, while done still pulses per result. start is ignored after the first accept.
- Undefined: single-shot; each measurement requires a start pulse.

Test Plan:
- GATE_CYCLES=100, sig period 10 clk (50% duty), start -> one done pulse; ref_cnt=100, sig_cnt=10, overflow=0, no_signal=0.
- GATE_CYCLES=100, sig period 7 clk -> closing edge at 105; ref_cnt=105, sig_cnt=15.
- sig_in held 0, TIMEOUT_CYCLES=500, start -> done about 500 clk later; no_signal=1, ref_cnt=0, sig_cnt=0.
- CNT_W=8, GATE_CYCLES=300, sig period 10 -> ref_cnt=255, sig_cnt=30, overflow=1.
- start pulsed again mid-measurement -> ignored, single done. Then rst_n low mid-measurement -> busy=0, all outputs 0, no done.
- FREQ_METER_AUTO_EN defined, GATE_CYCLES=100, period 10, single start -> repeated done pulses each with ref_cnt=100, sig_cnt=10; busy stays 1.
